// File: rtl/tug_match_controller.sv
// Best-of-N tug-of-war match sequencer: starts rounds, clears the playfield
// between them, gates player input, tallies round wins, and drives score digits.
module tug_match_controller #(
    parameter int WIN_ROUNDS   = 3,
    parameter int HOLD_CYCLES  = 4,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       roundWinL,
    input  logic       roundWinR,
    output logic       fieldReset,
    output logic       playEnable,
    output logic [3:0] scoreL,
    output logic [3:0] scoreR,
    output logic [6:0] hexL,
    output logic [6:0] hexR,
    output logic [1:0] matchWinner,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PLAY,
        S_HOLD,
        S_DONE
    } state_t;

    // The counter only ever holds a load value (length-1) counting down to 0.
    localparam int MAXC = (HOLD_CYCLES > CLEAR_CYCLES) ? HOLD_CYCLES : CLEAR_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
    localparam logic [3:0]    WIN_CNT    = 4'(WIN_ROUNDS);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    score_l_q, score_l_d;
    logic [3:0]    score_r_q, score_r_d;
    logic [1:0]    winner_q, winner_d;
    logic          start_prev_q, start_prev_d;
    logic          field_reset_q, field_reset_d;
    logic          play_enable_q, play_enable_d;
    logic          busy_q, busy_d;
    logic          start_edge;
    logic [3:0]    score_l_inc, score_r_inc;

    // Active-low 7-segment decode; anything outside 0..9 blanks the digit.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Next-state, score and output computation; outputs follow the next state
    // so that they are registered alongside it.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        score_l_d    = score_l_q;
        score_r_d    = score_r_q;
        winner_d     = winner_q;
        start_prev_d = start;
        start_edge   = start & ~start_prev_q;
        score_l_inc  = score_l_q + 4'd1;
        score_r_inc  = score_r_q + 4'd1;

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_CLEAR;
                    cnt_d   = CLEAR_LOAD;
                end
            end
            S_CLEAR: begin
                if (cnt_q == '0) begin
                    state_d = S_PLAY;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_PLAY: begin
                if (roundWinL && !roundWinR) begin
                    score_l_d = score_l_inc;
                    if (score_l_inc == WIN_CNT) begin
                        state_d  = S_DONE;
                        winner_d = 2'b10;
                    end else begin
                        state_d = S_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end else if (roundWinR && !roundWinL) begin
                    score_r_d = score_r_inc;
                    if (score_r_inc == WIN_CNT) begin
                        state_d  = S_DONE;
                        winner_d = 2'b01;
                    end else begin
                        state_d = S_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end else if (roundWinL && roundWinR) begin
                    // Tie: nobody scores, the round is replayed after the hold.
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_CLEAR;
                    cnt_d   = CLEAR_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                if (start_edge) begin
                    state_d   = S_CLEAR;
                    cnt_d     = CLEAR_LOAD;
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    winner_d  = 2'b00;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        field_reset_d = (state_d == S_IDLE) || (state_d == S_CLEAR);
        play_enable_d = (state_d == S_PLAY);
        busy_d        = (state_d == S_CLEAR) || (state_d == S_PLAY) || (state_d == S_HOLD);
    end

    // Single state register for the whole controller.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            score_l_q     <= 4'd0;
            score_r_q     <= 4'd0;
            winner_q      <= 2'b00;
            start_prev_q  <= 1'b1;
            field_reset_q <= 1'b1;
            play_enable_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            winner_q      <= winner_d;
            start_prev_q  <= start_prev_d;
            field_reset_q <= field_reset_d;
            play_enable_q <= play_enable_d;
            busy_q        <= busy_d;
        end
    end

    assign fieldReset  = field_reset_q;
    assign playEnable  = play_enable_q;
    assign busy        = busy_q;
    assign scoreL      = score_l_q;
    assign scoreR      = score_r_q;
    assign matchWinner = winner_q;
    assign hexL        = seg7(score_l_q);
    assign hexR        = seg7(score_r_q);

endmodule

// File: tb/tb_tug_match_controller.sv
// Bench for tug_match_controller: directed vector table, hand sequences for
// restart/reset corners, and randomized play against a timeline model.
module tb_tug_match_controller;

    localparam int WIN_ROUNDS   = 3;
    localparam int HOLD_CYCLES  = 4;
    localparam int CLEAR_CYCLES = 2;

    logic       clk = 1'b0;
    logic       reset, start, roundWinL, roundWinR;
    logic       fieldReset, playEnable, busy;
    logic [3:0] scoreL, scoreR;
    logic [6:0] hexL, hexR;
    logic [1:0] matchWinner;

    int total = 0;
    int bad   = 0;

    tug_match_controller #(
        .WIN_ROUNDS  (WIN_ROUNDS),
        .HOLD_CYCLES (HOLD_CYCLES),
        .CLEAR_CYCLES(CLEAR_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .roundWinL  (roundWinL),
        .roundWinR  (roundWinR),
        .fieldReset (fieldReset),
        .playEnable (playEnable),
        .scoreL     (scoreL),
        .scoreR     (scoreR),
        .hexL       (hexL),
        .hexR       (hexR),
        .matchWinner(matchWinner),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Digit patterns, index = value.
    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    // Model: phase of the match plus the absolute edge number at which the
    // current timed phase ends.
    localparam int P_IDLE = 0, P_CLEAR = 1, P_PLAY = 2, P_HOLD = 3, P_DONE = 4;
    int m_phase, m_end, m_edge, m_sl, m_sr, m_win;
    bit m_sprev;

    task automatic model_edge(input bit r, input bit s, input bit l, input bit w);
        bit e;
        e       = s && !m_sprev;
        m_sprev = s;
        m_edge++;
        if (r) begin
            m_phase = P_IDLE; m_sl = 0; m_sr = 0; m_win = 0; m_sprev = 1;
        end else begin
            case (m_phase)
                P_IDLE:  if (e) begin m_phase = P_CLEAR; m_end = m_edge + CLEAR_CYCLES; end
                P_CLEAR: if (m_edge == m_end) m_phase = P_PLAY;
                P_PLAY: begin
                    if (l != w) begin
                        if (l) m_sl++; else m_sr++;
                        if (m_sl == WIN_ROUNDS || m_sr == WIN_ROUNDS) begin
                            m_phase = P_DONE; m_win = l ? 2 : 1;
                        end else begin
                            m_phase = P_HOLD; m_end = m_edge + HOLD_CYCLES;
                        end
                    end else if (l && w) begin
                        m_phase = P_HOLD; m_end = m_edge + HOLD_CYCLES;
                    end
                end
                P_HOLD:  if (m_edge == m_end) begin m_phase = P_CLEAR; m_end = m_edge + CLEAR_CYCLES; end
                P_DONE:  if (e) begin
                    m_phase = P_CLEAR; m_end = m_edge + CLEAR_CYCLES;
                    m_sl = 0; m_sr = 0; m_win = 0;
                end
                default: m_phase = P_IDLE;
            endcase
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("fieldReset", fieldReset, (m_phase == P_IDLE || m_phase == P_CLEAR) ? 1 : 0);
        chk("playEnable", playEnable, (m_phase == P_PLAY) ? 1 : 0);
        chk("busy", busy, (m_phase == P_CLEAR || m_phase == P_PLAY || m_phase == P_HOLD) ? 1 : 0);
        chk("scoreL", scoreL, m_sl);
        chk("scoreR", scoreR, m_sr);
        chk("matchWinner", matchWinner, m_win);
        chk("hexL", hexL, seg_tab[m_sl]);
        chk("hexR", hexR, seg_tab[m_sr]);
    endtask

    // Apply one cycle of inputs, clock, and compare against the model.
    task automatic step(input bit r, input bit s, input bit l, input bit w);
        reset = r; start = s; roundWinL = l; roundWinR = w;
        @(posedge clk);
        model_edge(r, s, l, w);
        #1;
        chk_model();
        $display("cyc %0d rst=%0b st=%0b wl=%0b wr=%0b -> fr=%0b pe=%0b sL=%0d sR=%0d win=%0d busy=%0b",
                 m_edge, r, s, l, w, fieldReset, playEnable, scoreL, scoreR, matchWinner, busy);
    endtask

    task automatic wait_play();
        int n = 0;
        while (!playEnable && n < 40) begin
            step(0, 0, 0, 0);
            n++;
        end
        chk("wait_play_timeout", playEnable, 1);
    endtask

    typedef struct {
        bit r, s, l, w;
        bit fr, pe;
        int sl, sr, win;
        bit bz;
    } vec_t;

    vec_t vt [13];

    initial begin
        m_phase = P_IDLE; m_end = 0; m_edge = 0; m_sl = 0; m_sr = 0; m_win = 0; m_sprev = 1;
        reset = 1; start = 0; roundWinL = 0; roundWinR = 0;

        vt[0]  = '{1,0,0,0, 1,0, 0,0,0, 0};
        vt[1]  = '{0,0,0,0, 1,0, 0,0,0, 0};
        vt[2]  = '{0,1,0,0, 1,0, 0,0,0, 1};
        vt[3]  = '{0,1,0,0, 1,0, 0,0,0, 1};
        vt[4]  = '{0,0,0,0, 0,1, 0,0,0, 1};
        vt[5]  = '{0,0,1,0, 0,0, 1,0,0, 1};
        vt[6]  = '{0,0,0,0, 0,0, 1,0,0, 1};
        vt[7]  = '{0,0,0,0, 0,0, 1,0,0, 1};
        vt[8]  = '{0,0,0,0, 0,0, 1,0,0, 1};
        vt[9]  = '{0,0,0,0, 1,0, 1,0,0, 1};
        vt[10] = '{0,0,0,0, 1,0, 1,0,0, 1};
        vt[11] = '{0,0,0,0, 0,1, 1,0,0, 1};
        vt[12] = '{0,0,1,1, 0,0, 1,0,0, 1};

        for (int i = 0; i < 13; i++) begin
            step(vt[i].r, vt[i].s, vt[i].l, vt[i].w);
            chk($sformatf("vec%0d_fr", i), fieldReset, vt[i].fr);
            chk($sformatf("vec%0d_pe", i), playEnable, vt[i].pe);
            chk($sformatf("vec%0d_sL", i), scoreL, vt[i].sl);
            chk($sformatf("vec%0d_sR", i), scoreR, vt[i].sr);
            chk($sformatf("vec%0d_win", i), matchWinner, vt[i].win);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].bz);
        end
        chk("hexL_one", hexL, 7'b1111001);

        // Right takes three rounds; extra wins in DONE change nothing.
        for (int k = 0; k < 3; k++) begin
            wait_play();
            step(0, 0, 0, 1);
        end
        chk("done_scoreR", scoreR, 3);
        chk("done_hexR", hexR, 7'b0110000);
        chk("done_winner", matchWinner, 2'b01);
        chk("done_busy", busy, 0);
        chk("done_pe", playEnable, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1);
        chk("done_stable_scoreR", scoreR, 3);

        // Restart from DONE, holding start high the whole time.
        step(0, 1, 0, 0);
        chk("restart_scoreL", scoreL, 0);
        chk("restart_scoreR", scoreR, 0);
        chk("restart_winner", matchWinner, 0);
        chk("restart_fr", fieldReset, 1);
        step(0, 1, 0, 0);
        chk("restart_fr2", fieldReset, 1);
        step(0, 1, 0, 0);
        chk("restart_play", playEnable, 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 1);
            for (int j = 0; j < HOLD_CYCLES + CLEAR_CYCLES; j++) step(0, 1, 0, 0);
        end
        chk("held_start_done", matchWinner, 2'b01);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0);
        chk("held_start_no_restart", busy, 0);

        // Start held through reset: stays idle.
        step(1, 1, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0);
        chk("held_reset_idle_busy", busy, 0);
        chk("held_reset_idle_fr", fieldReset, 1);

        // Reset in HOLD with scoreL = 2.
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        wait_play();
        step(0, 0, 1, 0);
        wait_play();
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("hold_scoreL2", scoreL, 2);
        step(1, 0, 0, 0);
        chk("rst_hold_scoreL", scoreL, 0);
        chk("rst_hold_fr", fieldReset, 1);
        chk("rst_hold_busy", busy, 0);

        // Randomized play against the model.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tug_match_controller.md
Name: tug_match_controller

Overview:
- Sequences a best-of-N tug-of-war match around the existing playfield (light chain plus round win-detect FSM).
- Starts rounds and clears the playfield between them via a field reset pulse.
- Gates player/CPU input with a play enable, tallies round wins per side, declares the match winner, and drives two score HEX digits.

Parameters:
- WIN_ROUNDS, 3: round wins needed to take the match. Legal range 1..9.
- HOLD_CYCLES, 4: cycles the round result is held on display before clearing. Must be ≥1.
- CLEAR_CYCLES, 2: cycles fieldReset is asserted to clear the playfield. Must be ≥1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset; clock is clk
- start  input  1  start/restart button, level. Block edge-detects it internally.
- roundWinL  input  1  level from win-detect: left player won the current round
- roundWinR  input  1  level from win-detect: right player won the current round
- fieldReset  output  1  reset to light chain and win-detect logic
- playEnable  output  1  high while key/CPU presses may move the rope
- scoreL  output  4  left round-win count
- scoreR  output  4  right round-win count
- hexL  output  7  active-low 7-seg pattern of scoreL
- hexR  output  7  active-low 7-seg pattern of scoreR
- matchWinner  output  2  00 none, 10 left, 01 right
- busy  output  1  high in CLEAR, PLAY, HOLD

Behaviour:
- All state is posedge clk. reset overrides everything in any state.
- Reset values: state IDLE; scoreL = scoreR = 0; matchWinner = 00; fieldReset = 1; playEnable = 0; busy = 0; hexL = hexR = 7'b1000000 ("0"); startPrev = 1.
- Start edge:
  - startEdge = start & ~startPrev; startPrev <= start every cycle.
  - startPrev resets to 1, so a button held through reset produces no start until it is released and pressed again.
- States and outputs:
  - IDLE: fieldReset = 1, playEnable = 0. startEdge → CLEAR, load counter with CLEAR_CYCLES-1.
  - CLEAR: fieldReset = 1, playEnable = 0. Counter decrements each cycle; at 0 → PLAY. fieldReset is high for exactly CLEAR_CYCLES cycles.
  - PLAY: fieldReset = 0, playEnable = 1. roundWin inputs are sampled every cycle:
    - Only roundWinL: scoreL <= scoreL+1. If scoreL+1 == WIN_ROUNDS → DONE with matchWinner <= 10, else → HOLD with counter = HOLD_CYCLES-1.
    - Only roundWinR: symmetric; matchWinner <= 01.
    - Both high in the same cycle: tie. No score change → HOLD; the round is replayed.
    - Neither: stay in PLAY.
  - HOLD: fieldReset = 0 (result stays visible), playEnable = 0. Counter decrements; at 0 → CLEAR with counter = CLEAR_CYCLES-1.
  - DONE: fieldReset = 0, playEnable = 0, busy = 0; scores and matchWinner held. startEdge → CLEAR with scoreL = scoreR = 0, matchWinner = 00, all updated at the same edge.
- Latency:
  - A round win sampled at edge t updates score, hex, and state at edge t.
  - playEnable is low from the cycle after t.
  - A scoring input is counted once per round, because the state leaves PLAY on the same edge.
- startEdge is ignored in CLEAR, PLAY and HOLD.
- roundWin inputs are ignored outside PLAY.
- Scores never exceed WIN_ROUNDS. No wrap-around is possible.
- hex patterns are combinational from the score registers, active-low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Other values = 1111111.
- busy is high exactly in CLEAR, PLAY and HOLD.
- Reset mid-operation: at the next edge, all registers return to their reset values regardless of state or counter.

Test Plan (defaults WIN_ROUNDS = 3, HOLD_CYCLES = 4, CLEAR_CYCLES = 2):
- Reset, start = 0, then start 0→1 → fieldReset high 2 more cycles; then playEnable = 1, busy = 1, scores 0, hexL = hexR = 1000000.
- In PLAY, roundWinL = 1 for one cycle → scoreL = 1, hexL = 1111001, playEnable = 0 next cycle. After 4 HOLD + 2 CLEAR cycles, playEnable = 1 again.
- roundWinL = roundWinR = 1 in the same cycle in PLAY → scores unchanged (1/0), HOLD entered, round replayed.
- Right wins 3 rounds → scoreR = 3, hexR = 0110000, matchWinner = 01, busy = 0, playEnable = 0. Further roundWinR pulses cause no change.
- In DONE, start edge → scores 0, matchWinner = 00 at that edge; fieldReset high 2 cycles, then PLAY. Holding start high continuously causes no second restart.
- start held high through reset and after it → stays IDLE. Assert reset during HOLD with scoreL = 2 → next cycle IDLE, scores 0, fieldReset = 1.
